// File: rtl/store_size_pkg.sv
// Shared encodings for the store/load size paths and the store RMW sequencer states.
// Pure declarations: no latency, no flow control.
package store_size_pkg;

   localparam logic [1:0] SS_WORD = 2'b00;
   localparam logic [1:0] SS_HALF = 2'b01;
   localparam logic [1:0] SS_BYTE = 2'b10;
   localparam logic [1:0] SS_RSVD = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      READ  = 2'b01,
      WRITE = 2'b10,
      FIN   = 2'b11
   } state_t;

   // Sub-word stores must fetch the surrounding word before writing it back.
   function automatic logic ss_needs_read(input logic [1:0] ss);
      return (ss == SS_HALF) || (ss == SS_BYTE);
   endfunction

endpackage

// File: rtl/store_merge.sv
// Lane merge of new store data into the old memory word (low-order lanes, as in the load path).
// Purely combinational: zero latency, no flow control.
module store_merge
   import store_size_pkg::*;
(
   input  logic [1:0]  ss,
   input  logic [31:0] old_word,
   input  logic [31:0] new_data,
   output logic [31:0] merged
);

   always_comb begin
      merged = new_data;
      case (ss)
         SS_HALF: merged = {old_word[31:16], new_data[15:0]};
         SS_BYTE: merged = {old_word[31:8],  new_data[7:0]};
         default: merged = new_data;
      endcase
   end

endmodule

// File: rtl/store_size_rmw.sv
// Store-size sequencer: direct word write, read-merge-write for half/byte, error for reserved size.
// Latency 2 (word), MEM_LAT+2 (half/byte), 1 (reserved); start ignored while busy, no queueing.
module store_size_rmw
   import store_size_pkg::*;
#(
   parameter int unsigned MEM_LAT = 1
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  SS,
   input  logic [31:0] addr,
   input  logic [31:0] w_B,
   input  logic [31:0] mem_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_wr,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

   state_t      state;
   state_t      state_nxt;
   logic [2:0]  lat_cnt;
   logic [1:0]  ss_q;
   logic [31:0] wb_q;
   logic        err_q;
   logic [31:0] merged;
   logic        accept;
   logic        read_last;

   assign accept    = (state == IDLE) && start;
   assign read_last = (state == READ) && (lat_cnt == LAT_LAST);

   store_merge u_merge (
      .ss       (ss_q),
      .old_word (mem_rdata),
      .new_data (wb_q),
      .merged   (merged)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               if (SS == SS_WORD) begin
                  state_nxt = WRITE;
               end else if (ss_needs_read(SS)) begin
                  state_nxt = READ;
               end else begin
                  state_nxt = FIN;
               end
            end
         end
         READ: begin
            if (read_last) begin
               state_nxt = WRITE;
            end
         end
         WRITE:   state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Control outputs decode the state only, so reset kills an in-flight write immediately.
   always_comb begin
      mem_wr = (state == WRITE);
      busy   = (state == READ) || (state == WRITE);
      done   = (state == FIN);
      err    = (state == FIN) && err_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ss_q      <= SS_WORD;
         wb_q      <= '0;
         err_q     <= 1'b0;
         lat_cnt   <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         if (accept) begin
            ss_q     <= SS;
            wb_q     <= w_B;
            mem_addr <= addr;
            err_q    <= (SS == SS_RSVD);
            lat_cnt  <= '0;
            if (SS == SS_WORD) begin
               mem_wdata <= w_B;
            end
         end else if ((state == READ) && !read_last) begin
            lat_cnt <= lat_cnt + 3'd1;
         end
         // Reserved requests leave mem_wdata untouched; it simply holds the previous store.
         if (read_last) begin
            mem_wdata <= merged;
         end
      end
   end

endmodule
